mu0_core: RTL and testbench
===========================

// Module: mu0_core
// PURPOSE
//  Multi-cycle MU0 processor core: fetches, decodes and executes 16-bit MU0 instructions.
//  Sits directly upstream of the unified instruction/data memory on the shared memrq/rnw/addr/data bus.
//  Memory read data is combinational within the same cycle. Memory writes are captured on negedge clk.
//  Instruction word = {opcode[3:0], operand S[11:0]}.
//  Encoding: LDA=0 STO=1 ADD=2 SUB=3 JMP=4 JGE=5 JNE=6 STP=7; opcodes 8-15 reserved.
// PARAMETERS
//  ADDR_W    12     address/operand width; opcode width is DATA_W-ADDR_W (must be 4)
//  DATA_W    16     data bus, accumulator and instruction width
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk      in     1       rising-edge system clock
//  rstn     in     1       asynchronous active-low reset
//  memrq    out    1       memory request; 1 = bus cycle active this clock
//  rnw      out    1       1 = read, 0 = write (meaningful only when memrq=1)
//  addr     out    ADDR_W  memory address
//  data     inout  DATA_W  driven with ACC only when memrq & !rnw, else 'z
//  fetch    out    1       1 during FETCH state (bench/trace aid)
//  halted   out    1       1 once STP has executed; sticky until reset
//  acc      out    DATA_W  accumulator value (observability)
// BEHAVIOUR
//  Registers: PC[ADDR_W], IR[DATA_W], ACC[DATA_W], state{FETCH,EXEC,HALT}.
//  Reset (async, rstn=0):
//   - state=FETCH, PC=RESET_PC, IR=0, ACC=0.
//   - memrq=0, halted=0, data released; takes effect immediately, mid-cycle included.
//   - On rstn release, first FETCH begins on the next rising edge.
//  FETCH (1 cycle): memrq=1, rnw=1, addr=PC.
//   - At posedge: IR<=data, PC<=PC+1 (wraps 0xFFF->0x000), state<=EXEC.
//  EXEC (1 cycle), by IR[15:12], with S=IR[11:0]:
//   - LDA: memrq=1, rnw=1, addr=S; posedge ACC<=data.
//   - ADD: memrq=1, rnw=1, addr=S; posedge ACC<=ACC+data (mod 2^16, carry dropped).
//   - SUB: memrq=1, rnw=1, addr=S; posedge ACC<=ACC-data (mod 2^16, borrow dropped).
//   - STO: memrq=1, rnw=0, addr=S; data=ACC for the whole cycle (memory samples at negedge); ACC unchanged.
//   - JMP: memrq=0; PC<=S.
//   - JGE: memrq=0; PC<=S iff ACC[15]==0, else PC unchanged.
//   - JNE: memrq=0; PC<=S iff ACC!=0, else PC unchanged.
//   - STP: memrq=0; state<=HALT.
//   - reserved 8-15: memrq=0; no register change (NOP).
//   - All except STP: state<=FETCH.
//  HALT: memrq=0, data='z, halted=1, all registers frozen; exit only via reset.
//  Jump conditions use ACC as held at the start of EXEC.
//  Timing: every instruction takes exactly 2 clocks; no pipelining, no stalls.
//  Self-modifying code: a STO to PC's target is seen by the next FETCH.
//  addr and rnw are registered-state decodes. When memrq=0: addr=PC, rnw=1.
//  No X propagation: data is never driven while memrq=0 or rnw=1.
// TESTING
//  1. Reset: hold rstn=0 3 clks -> memrq=0, halted=0, acc=0, data='z.
//     First cycle after release: fetch=1, addr=0x000, rnw=1.
//  2. Program run. mem[0..10] = LDA 64, SUB 65, JNE 6, LDA 64, ADD 65, JMP 9, LDA 64, SUB 66,
//     SUB 66, STO 64, STP; mem[64]=4444, mem[65]=2222, mem[66]=1111.
//     -> JNE taken; halted=1 after 16th rising edge; mem[0x64]=0x2222; acc=0x2222.
//  3. Arithmetic wrap: ACC=0xFFFF, ADD of 0x0001 -> ACC=0x0000.
//     Then SUB of 0x0001 -> ACC=0xFFFF; then JGE not taken, JNE taken.
//  4. STO bus check: during STO EXEC -> memrq=1, rnw=0, addr=S, data=ACC stable across negedge.
//     In all other cycles data='z.
//  5. Mid-run reset: assert rstn=0 during a STO EXEC -> memrq drops same cycle, no memory write.
//     Core restarts at PC=0.
//  6. PC wrap and reserved opcode: JMP 0xFFF with mem[0xFFF]=0x8000 (reserved) -> NOP, PC wraps to 0x000.
//     Next fetch addr=0x000.

Source files
------------

// File: rtl/mu0_core.sv
// mu0_core: multi-cycle MU0 processor, one FETCH and one EXEC clock per instruction on a shared memory bus
module mu0_core #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              memrq,
  output logic              rnw,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              fetch,
  output logic              halted,
  output logic [DATA_W-1:0] acc
);
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2;
  localparam logic [3:0] LDA = 4'd0, STO = 4'd1, ADD = 4'd2, SUB = 4'd3,
                         JMP = 4'd4, JGE = 4'd5, JNE = 4'd6, STP = 4'd7;
  logic [1:0] state;
  logic [ADDR_W-1:0] pc, s;
  logic [DATA_W-1:0] ir;
  logic [3:0] op;
  logic mem_op, take;
  assign op = ir[DATA_W-1:ADDR_W];
  assign s = ir[ADDR_W-1:0];
  assign fetch = state == FETCH;
  assign halted = state == HALT;
  assign mem_op = state == EXEC && op <= SUB;
  // reset gates the request asynchronously so a bus cycle is abandoned mid-clock
  assign memrq = rstn && (fetch || mem_op);
  assign rnw = !(mem_op && op == STO);
  assign addr = mem_op ? s : pc;
  assign data = (memrq && !rnw) ? acc : 'z;
  assign take = op == JMP || (op == JGE && !acc[DATA_W-1]) || (op == JNE && |acc);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      acc <= '0;
    end else if (fetch) begin
      ir <= data;
      pc <= pc + ADDR_W'(1);
      state <= EXEC;
    end else if (state == EXEC) begin
      state <= op == STP ? HALT : FETCH;
      pc <= take ? s : pc;
      acc <= op == LDA ? data : op == ADD ? acc + data : op == SUB ? acc - data : acc;
    end
endmodule

// File: tb/tb_mu0_core.sv
// tb_mu0_core: directed programs on a unified memory model with hand-computed expectations
module tb_mu0_core;
  logic clk, rstn;
  logic memrq, rnw, fetch, halted;
  logic [11:0] addr;
  logic [15:0] acc;
  wire  [15:0] data;
  logic [15:0] mem [0:4095];
  logic ld, clr;
  logic [11:0] ld_a;
  logic [15:0] ld_d;
  int n_chk, n_fail;

  mu0_core dut (
    .clk(clk), .rstn(rstn), .memrq(memrq), .rnw(rnw), .addr(addr),
    .data(data), .fetch(fetch), .halted(halted), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data = (memrq && rnw) ? mem[addr] : 16'bz;

  always @(negedge clk)
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    end else if (ld) mem[ld_a] <= ld_d;
    else if (memrq && !rnw) mem[addr] <= data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_a = a;
    ld_d = d;
    ld = 1'b1;
    @(negedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic release_rst();
    repeat (3) @(posedge clk);
    #1;
    check("rst_memrq", memrq, 0);
    check("rst_halted", halted, 0);
    check("rst_acc", acc, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("first_fetch", fetch, 1);
    check("first_addr", addr, 12'h000);
    check("first_rnw", rnw, 1);
    check("first_memrq", memrq, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    n_chk = 0;
    n_fail = 0;
    ld = 1'b0;
    clr = 1'b0;
    ld_a = '0;
    ld_d = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // reset with zeroed memory: core runs LDA 0 forever
    clear_mem();
    release_rst();
    step(2);
    check("zero_acc", acc, 16'h0000);
    check("zero_fetch", fetch, 1);

    // reference program: JNE taken, ends with 0x2222 stored and in ACC
    rstn = 1'b0;
    clear_mem();
    poke(12'h000, 16'h0064); poke(12'h001, 16'h3065); poke(12'h002, 16'h6006);
    poke(12'h003, 16'h0064); poke(12'h004, 16'h2065); poke(12'h005, 16'h4009);
    poke(12'h006, 16'h0064); poke(12'h007, 16'h3066); poke(12'h008, 16'h3066);
    poke(12'h009, 16'h1064); poke(12'h00A, 16'h7000);
    poke(12'h064, 16'h4444); poke(12'h065, 16'h2222); poke(12'h066, 16'h1111);
    release_rst();
    edges = 0;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      edges = e;
      if (halted) break;
    end
    check("halt_edges", edges, 16);
    check("prog_mem64", mem[12'h064], 16'h2222);
    check("prog_acc", acc, 16'h2222);
    check("halt_pc", addr, 12'h00B);
    step(4);
    check("halt_sticky", halted, 1);
    check("halt_memrq", memrq, 0);
    check("halt_acc", acc, 16'h2222);

    // arithmetic wrap and conditional jumps on 0xFFFF
    rstn = 1'b0;
    clear_mem();
    poke(12'h000, 16'h0070); poke(12'h001, 16'h2071); poke(12'h002, 16'h3071);
    poke(12'h003, 16'h5020); poke(12'h004, 16'h6030); poke(12'h005, 16'h7000);
    poke(12'h020, 16'h7000); poke(12'h030, 16'h7000);
    poke(12'h070, 16'hFFFF); poke(12'h071, 16'h0001);
    release_rst();
    step(2); check("wrap_lda", acc, 16'hFFFF);
    step(2); check("wrap_add", acc, 16'h0000);
    step(2); check("wrap_sub", acc, 16'hFFFF);
    step(2); check("jge_not_taken", addr, 12'h004);
    check("jge_fetch", fetch, 1);
    step(2); check("jne_taken", addr, 12'h030);
    step(2); check("jne_halt", halted, 1);
    check("jne_halt_pc", addr, 12'h031);

    // STO bus cycle
    rstn = 1'b0;
    clear_mem();
    poke(12'h000, 16'h0070); poke(12'h001, 16'h1050); poke(12'h002, 16'h7000);
    poke(12'h070, 16'hBEEF);
    release_rst();
    step(1);
    check("lda_memrq", memrq, 1);
    check("lda_rnw", rnw, 1);
    check("lda_addr", addr, 12'h070);
    step(1);
    check("sto_fetch_rnw", rnw, 1);
    step(1);
    check("sto_memrq", memrq, 1);
    check("sto_rnw", rnw, 0);
    check("sto_addr", addr, 12'h050);
    check("sto_data", data, 16'hBEEF);
    @(negedge clk);
    #1;
    check("sto_data_neg", data, 16'hBEEF);
    check("sto_mem", mem[12'h050], 16'hBEEF);
    step(1);
    check("post_sto_rnw", rnw, 1);
    check("post_sto_acc", acc, 16'hBEEF);

    // reset asserted mid STO: no write, restart at 0
    rstn = 1'b0;
    clear_mem();
    poke(12'h000, 16'h0070); poke(12'h001, 16'h1050); poke(12'h002, 16'h7000);
    poke(12'h070, 16'h1234); poke(12'h050, 16'hAAAA);
    release_rst();
    step(3);
    check("mid_sto_rnw", rnw, 0);
    check("mid_sto_memrq", memrq, 1);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_memrq", memrq, 0);
    check("mid_rst_acc", acc, 16'h0000);
    @(negedge clk);
    #1;
    check("mid_rst_nowrite", mem[12'h050], 16'hAAAA);
    release_rst();
    step(2);
    check("restart_acc", acc, 16'h1234);

    // PC wrap through a reserved opcode
    rstn = 1'b0;
    clear_mem();
    poke(12'h000, 16'h4FFF); poke(12'hFFF, 16'h8000);
    release_rst();
    step(2);
    check("jmp_fetch", fetch, 1);
    check("jmp_addr", addr, 12'hFFF);
    step(1);
    check("nop_memrq", memrq, 0);
    check("nop_pc_wrap", addr, 12'h000);
    step(1);
    check("wrap_fetch", fetch, 1);
    check("wrap_addr", addr, 12'h000);
    check("nop_acc", acc, 16'h0000);
    check("nop_halted", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
